// File: rtl/sine_sub_meas_pkg.sv
// Shared types and sample-range constants for the sine_* measurement blocks.
// Provides the window FSM state encoding and the peak-to-peak helper.
package sine_sub_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic signed [12:0] SMAX = 13'sh0FFF;  // +4095
    localparam logic signed [12:0] SMIN = 13'sh1000;  // -4096

    // Sign-extend by one bit so max-min (up to 8191) never overflows.
    function automatic logic [13:0] calc_vpp(input logic signed [12:0] hi,
                                             input logic signed [12:0] lo);
        return {hi[12], hi} - {lo[12], lo};
    endfunction

endpackage

// File: rtl/sine_sub_meas.sv
// Windowed max/min/peak-to-peak and rising zero-crossing measurement of the
// two-tone difference signal; one window per accepted start.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; win_len latched on acceptance
// ARM     | running max/min/count/crossings preloaded
// MEAS    | accumulating valid samples until count reaches length
// DONE    | running results copied to outputs; done pulses next cycle
module sine_sub_meas
    import sine_sub_meas_pkg::*;
#(
    parameter int WIN_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [12:0]      din,
    input  logic                    din_valid,
    input  logic                    start,
    input  logic [WIN_W-1:0]        win_len,
    output logic                    busy,
    output logic                    done,
    output logic signed [12:0]      vmax,
    output logic signed [12:0]      vmin,
    output logic [13:0]             vpp,
    output logic [WIN_W-1:0]        zc_cnt
);

    state_t             state, state_nxt;
    logic [WIN_W-1:0]   len_q;
    logic [WIN_W-1:0]   cnt;
    logic [WIN_W-1:0]   cnt_inc;
    logic [WIN_W-1:0]   zc;
    logic signed [12:0] run_max;
    logic signed [12:0] run_min;
    logic               prev_neg;
    logic               last_smp;

    assign cnt_inc  = cnt + 1'b1;
    assign last_smp = din_valid && (cnt_inc == len_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                busy      = 1'b1;
                state_nxt = ST_MEAS;
            end
            ST_MEAS: begin
                busy = 1'b1;
                if (last_smp) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Results and done are registered together so a consumer sampling on
    // done always sees the matching window values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q    <= '0;
            cnt      <= '0;
            zc       <= '0;
            run_max  <= '0;
            run_min  <= '0;
            prev_neg <= 1'b0;
            done     <= 1'b0;
            vmax     <= '0;
            vmin     <= '0;
            vpp      <= '0;
            zc_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q <= (win_len == '0) ? WIN_W'(1) : win_len;
                    end
                end
                ST_ARM: begin
                    run_max  <= SMIN;
                    run_min  <= SMAX;
                    cnt      <= '0;
                    zc       <= '0;
                    prev_neg <= 1'b0;
                end
                ST_MEAS: begin
                    if (din_valid) begin
                        if (din > run_max) run_max <= din;
                        if (din < run_min) run_min <= din;
                        cnt      <= cnt_inc;
                        prev_neg <= din[12];
                        if (prev_neg && !din[12] && (zc != '1)) begin
                            zc <= zc + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    vmax   <= run_max;
                    vmin   <= run_min;
                    vpp    <= calc_vpp(run_max, run_min);
                    zc_cnt <= zc;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sine_sub_meas.sv
// Directed self-checking bench for sine_sub_meas: window results, gaps,
// zero-edge crossings, zero length, extremes, DONE-cycle start and abort.
module tb_sine_sub_meas;

    localparam int WIN_W = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic signed [12:0]      din;
    logic                    din_valid;
    logic                    start;
    logic [WIN_W-1:0]        win_len;
    logic                    busy;
    logic                    done;
    logic signed [12:0]      vmax;
    logic signed [12:0]      vmin;
    logic [13:0]             vpp;
    logic [WIN_W-1:0]        zc_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int done_seen = 0;
    int done_mark;

    sine_sub_meas #(.WIN_W(WIN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .start     (start),
        .win_len   (win_len),
        .busy      (busy),
        .done      (done),
        .vmax      (vmax),
        .vmin      (vmin),
        .vpp       (vpp),
        .zc_cnt    (zc_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [12:0] d);
        din       = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    // Start accepted in IDLE, then one ARM cycle; returns with FSM in MEAS.
    task automatic begin_win(input logic [WIN_W-1:0] len);
        start   = 1'b1;
        win_len = len;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic chk_res(input string tag, input int emax, input int emin,
                           input int evpp, input int ezc);
        chk({tag, "_vmax"}, vmax, emax);
        chk({tag, "_vmin"}, vmin, emin);
        chk({tag, "_vpp"}, vpp, evpp);
        chk({tag, "_zc"}, zc_cnt, ezc);
    endtask

    initial begin
        rst       = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        start     = 1'b0;
        win_len   = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk_res("rst", 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // Window min/max: 100,-200,300,-50
        start   = 1'b1;
        win_len = 16'd4;
        tick();
        start = 1'b0;
        chk("t1_busy_arm", busy, 1);
        tick();
        send(13'sd100);
        send(-13'sd200);
        send(13'sd300);
        send(-13'sd50);
        chk("t1_done_early", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk_res("t1", 300, -200, 500, 1);
        tick();
        chk("t1_done_fall", done, 0);
        chk("t1_pulses", done_seen, 1);

        // Extremes, with a start request in the DONE cycle
        begin_win(16'd2);
        send(-13'sd4096);
        send(13'sd4095);
        start   = 1'b1;
        win_len = 16'd3;
        tick();
        start = 1'b0;
        chk("t2_done", done, 1);
        chk_res("t2", 4095, -4096, 8191, 1);
        tick();
        chk("t2_start_in_done_busy", busy, 0);
        tick();
        chk("t2_idle_busy", busy, 0);

        // Gaps: valid pattern 1,0,0,1,0,1
        begin_win(16'd3);
        send(13'sd5);
        tick();
        tick();
        send(13'sd7);
        tick();
        chk("t3_busy_gap", busy, 1);
        send(13'sd9);
        chk("t3_done_early", done, 0);
        tick();
        chk("t3_done", done, 1);
        chk_res("t3", 9, 5, 4, 0);
        tick();
        chk("t3_busy_after", busy, 0);

        // Zero edge: -1,0,-1,0,0 gives two rising crossings
        begin_win(16'd5);
        send(-13'sd1);
        send(13'sd0);
        send(-13'sd1);
        send(13'sd0);
        send(13'sd0);
        tick();
        chk("t4_done", done, 1);
        chk_res("t4", 0, -1, 1, 2);
        tick();

        // Window ending negative, then a window starting at 0: not counted
        begin_win(16'd1);
        send(-13'sd3);
        tick();
        chk_res("t4b", -3, -3, 0, 0);
        tick();
        begin_win(16'd2);
        send(13'sd0);
        send(13'sd5);
        tick();
        chk_res("t4c", 5, 0, 5, 0);
        tick();

        // Length 0 behaves as length 1
        begin_win(16'd0);
        send(13'sd42);
        chk("t5_done_early", done, 0);
        tick();
        chk("t5_done", done, 1);
        chk_res("t5", 42, 42, 0, 0);
        tick();

        // Abort: start len=8, restart attempts while busy, reset mid-window
        done_mark = done_seen;
        begin_win(16'd8);
        start   = 1'b1;
        win_len = 16'd2;
        send(13'sd10);
        send(13'sd20);
        start = 1'b0;
        send(13'sd30);
        tick();
        chk("t6_busy_len_kept", busy, 1);
        chk("t6_no_done_early", done_seen, done_mark);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_busy", busy, 0);
        chk("t6_async_done", done, 0);
        chk_res("t6", 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        send(13'sd11);
        send(13'sd12);
        tick();
        tick();
        chk("t6_no_restart_busy", busy, 0);
        chk("t6_no_done", done_seen, done_mark);
        chk_res("t6_hold", 0, 0, 0, 0);

        // Fresh window after abort
        begin_win(16'd2);
        send(13'sd1);
        send(13'sd2);
        tick();
        chk("t7_done", done, 1);
        chk_res("t7", 2, 1, 1, 0);
        tick();
        chk("t7_pulses", done_seen, done_mark + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
